// File: rtl/tpg_lfsr_param.sv
// tpg_lfsr_param: WIDTH-bit LFSR test-pattern generator with a loadable seed, start/busy/complete
// handshake, hold and pattern counter. Define TPG_ZERO_STATE_EN to add the all-zero state.
module tpg_lfsr_param #(
   parameter int unsigned      WIDTH = 3,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b110),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             hold,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             busy,
   output logic             complete,
   output logic [WIDTH:0]   pattern_count
);

`ifdef TPG_ZERO_STATE_EN
   localparam logic [WIDTH:0] PERIOD = {1'b1, {WIDTH{1'b0}}};
`else
   localparam logic [WIDTH:0] PERIOD = {1'b0, {WIDTH{1'b1}}};
`endif
   localparam logic [WIDTH:0] LAST = PERIOD - (WIDTH+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH:0]   count_q, count_d;
   logic             busy_q, busy_d;
   logic             complete_q, complete_d;

   logic             fb_c;
   logic [WIDTH-1:0] seed_eff_c;
   logic [WIDTH-1:0] next_pat_c;

   // Feedback and effective seed; without the zero state a zero seed would lock up the LFSR.
   always_comb begin
      fb_c = ^(data_q & TAPS);
`ifdef TPG_ZERO_STATE_EN
      fb_c       = fb_c ^ (data_q[WIDTH-2:0] == '0);
      seed_eff_c = seed_in;
`else
      seed_eff_c = (seed_in == '0) ? WIDTH'(1) : seed_in;
`endif
      next_pat_c = {data_q[WIDTH-2:0], fb_c};
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      seed_d  = seed_q;
      count_d = count_q;

      if (seed_load && (state_q != ST_RUN)) begin
         seed_d = seed_eff_c;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               data_d  = seed_load ? seed_eff_c : seed_q;
               count_d = '0;
            end
         end
         ST_RUN: begin
            if (!hold) begin
               data_d  = next_pat_c;
               count_d = count_q + (WIDTH+1)'(1);
               if (count_q == LAST) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d     = (state_d == ST_RUN);
      complete_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         data_q     <= SEED;
         seed_q     <= SEED;
         count_q    <= '0;
         busy_q     <= 1'b0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         seed_q     <= seed_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         complete_q <= complete_d;
      end
   end

   // valid follows hold within the same cycle so a paused pattern is never counted downstream.
   assign valid         = (state_q == ST_RUN) & ~hold;
   assign data_out      = data_q;
   assign busy          = busy_q;
   assign complete      = complete_q;
   assign pattern_count = count_q;

endmodule

// File: tb/tb_tpg_lfsr_param.sv
// Self-checking bench for tpg_lfsr_param: default 3-bit instance and an 8-bit (taps 8'hB8) instance.
module tb_tpg_lfsr_param;

`ifdef TPG_ZERO_STATE_EN
   localparam int P3     = 8;
   localparam int P8     = 256;
   localparam int ZS_IDX = 7;
`else
   localparam int P3     = 7;
   localparam int P8     = 255;
   localparam int ZS_IDX = 0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       start3, hold3, seed_load3;
   logic [2:0] seed_in3, data3;
   logic       valid3, busy3, complete3;
   logic [3:0] count3;
   logic       start8, hold8, seed_load8;
   logic [7:0] seed_in8, data8;
   logic       valid8, busy8, complete8;
   logic [8:0] count8;

   int errors = 0;
   int checks = 0;
   logic [2:0]  seq [8] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0};
   logic [31:0] q3 [$];
   logic [31:0] q8 [$];
   bit          seen [256];

   always #5 clock = ~clock;

   tpg_lfsr_param u_dut3 (
      .clock(clock), .reset(reset), .start(start3), .hold(hold3), .seed_load(seed_load3),
      .seed_in(seed_in3), .data_out(data3), .valid(valid3), .busy(busy3),
      .complete(complete3), .pattern_count(count3)
   );

   tpg_lfsr_param #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) u_dut8 (
      .clock(clock), .reset(reset), .start(start8), .hold(hold8), .seed_load(seed_load8),
      .seed_in(seed_in8), .data_out(data8), .valid(valid8), .busy(busy8),
      .complete(complete8), .pattern_count(count8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mnext8(input logic [7:0] x);
      logic fb;
      fb = ^(x & 8'hB8);
`ifdef TPG_ZERO_STATE_EN
      if (x[6:0] == 7'd0) fb = ~fb;
`endif
      return {x[6:0], fb};
   endfunction

   task automatic chk_reset3();
      chk("rst_data", 32'(data3), 32'd1);
      chk("rst_valid", 32'(valid3), 32'd0);
      chk("rst_busy", 32'(busy3), 32'd0);
      chk("rst_complete", 32'(complete3), 32'd0);
      chk("rst_count", 32'(count3), 32'd0);
   endtask

   // One full 3-bit sweep starting at table index 'first'; optional hold window and in-run load.
   task automatic sweep3(input int first, input bit do_load, input logic [2:0] load_val,
                         input int hold_after, input int hold_len, input int run_load_at);
      int consumed, cyc, held;
      logic [31:0] e;
      for (int k = 0; k < P3; k++) q3.push_back(32'(seq[(first + k) % P3]));
      start3 = 1'b1; seed_load3 = do_load; seed_in3 = load_val;
      @(negedge clock);
      start3 = 1'b0; seed_load3 = 1'b0;
      chk("start_busy", 32'(busy3), 32'd1);
      chk("start_complete_clr", 32'(complete3), 32'd0);
      chk("start_count", 32'(count3), 32'd0);
      consumed = 0; cyc = 0; held = 0;
      while (q3.size() > 0 && cyc < 64) begin
         seed_load3 = (consumed == run_load_at);
         seed_in3   = 3'b110;
         if (hold_len > 0 && consumed == hold_after && held < hold_len) begin
            hold3 = 1'b1; #1;
            chk("hold_valid", 32'(valid3), 32'd0);
            chk("hold_frozen", 32'(data3), 32'(seq[(first + consumed) % P3]));
            held++;
         end else begin
            hold3 = 1'b0; #1;
            if (valid3) begin
               e = q3.pop_front();
               chk("pattern", 32'(data3), e);
               consumed++;
            end else begin
               chk("valid_in_run", 32'(valid3), 32'd1);
            end
         end
         cyc++;
         @(negedge clock);
      end
      hold3 = 1'b0; seed_load3 = 1'b0;
      if (q3.size() > 0) begin
         chk("sweep_timeout", 32'(q3.size()), 32'd0);
         q3.delete();
      end
      #1;
      chk("done_complete", 32'(complete3), 32'd1);
      chk("done_busy", 32'(busy3), 32'd0);
      chk("done_valid", 32'(valid3), 32'd0);
      chk("done_data_seed", 32'(data3), 32'(seq[first % P3]));
      chk("done_count", 32'(count3), 32'(P3));
      chk("done_latency", 32'(cyc), 32'(P3 + hold_len));
   endtask

   initial begin
      int cyc;
      logic [7:0]  m;
      logic [31:0] e;
      reset = 1'b1;
      start3 = 0; hold3 = 0; seed_load3 = 0; seed_in3 = '0;
      start8 = 0; hold8 = 0; seed_load8 = 0; seed_in8 = '0;
      @(negedge clock);
      chk_reset3();
      reset = 1'b0;
      @(negedge clock);

      // Default sweep, then hold after 2nd pattern with an ignored in-run seed load, then plain restart.
      sweep3(0, 1'b0, 3'd0, -1, 0, -1);
      sweep3(0, 1'b0, 3'd0, 2, 3, 4);
      sweep3(0, 1'b0, 3'd0, -1, 0, -1);

      // Seed 011 loaded while idle in DONE, then start.
      seed_load3 = 1'b1; seed_in3 = 3'b011;
      @(negedge clock);
      seed_load3 = 1'b0;
      chk("load_keeps_data", 32'(data3), 32'd1);
      chk("load_keeps_done", 32'(complete3), 32'd1);
      sweep3(3, 1'b0, 3'd0, -1, 0, -1);

      // Zero seed loaded in the same cycle as start.
      sweep3(ZS_IDX, 1'b1, 3'd0, -1, 0, -1);

      // Reset at the 4th pattern of a sweep seeded with 011; restart must use SEED.
      start3 = 1'b1; seed_load3 = 1'b1; seed_in3 = 3'b011;
      @(negedge clock);
      start3 = 1'b0; seed_load3 = 1'b0;
      repeat (3) @(negedge clock);
      chk("pre_reset_4th", 32'(data3), 32'(seq[6]));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk_reset3();
      sweep3(0, 1'b0, 3'd0, -1, 0, -1);

      // 8-bit instance: full sweep, distinctness, return to seed, restart from DONE.
      m = 8'd1;
      for (int k = 0; k < P8; k++) begin
         q8.push_back(32'(m));
         m = mnext8(m);
      end
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0;
      cyc = 0;
      while (q8.size() > 0 && cyc < 600) begin
         #1;
         if (valid8) begin
            e = q8.pop_front();
            chk("w8_pattern", 32'(data8), e);
            chk("w8_distinct", 32'(seen[data8]), 32'd0);
            seen[data8] = 1'b1;
`ifndef TPG_ZERO_STATE_EN
            chk("w8_nonzero", 32'(data8 != 8'd0), 32'd1);
`endif
         end else begin
            chk("w8_valid", 32'(valid8), 32'd1);
         end
         cyc++;
         @(negedge clock);
      end
      if (q8.size() > 0) begin
         chk("w8_timeout", 32'(q8.size()), 32'd0);
         q8.delete();
      end
      chk("w8_complete", 32'(complete8), 32'd1);
      chk("w8_busy", 32'(busy8), 32'd0);
      chk("w8_data_seed", 32'(data8), 32'd1);
      chk("w8_count", 32'(count8), 32'(P8));

      start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0;
      chk("w8_restart_complete", 32'(complete8), 32'd0);
      chk("w8_restart_busy", 32'(busy8), 32'd1);
      chk("w8_restart_data", 32'(data8), 32'd1);
      chk("w8_restart_count", 32'(count8), 32'd0);
      cyc = 0;
      while (complete8 !== 1'b1 && cyc < 600) begin
         @(negedge clock);
         cyc++;
      end
      chk("w8_rerun_complete", 32'(complete8), 32'd1);
      chk("w8_rerun_latency", 32'(cyc), 32'(P8));
      chk("w8_rerun_count", 32'(count8), 32'(P8));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tpg_lfsr_param.md
# tpg_lfsr_param

Parametrised LFSR test-pattern generator for the BIST path: the successor to the fixed 3-bit TPG, generalised to WIDTH bits with a programmable tap mask. It adds a loadable seed, a start/busy/complete handshake, a pause input and a pattern counter. It drives the circuit-under-test inputs and tells the response analyser when each pattern is valid and when the sweep has finished.

## Interface
- WIDTH, 3: pattern width; legal range 2..32.
- TAPS, 3'b110 (WIDTH bits): feedback mask; bit i set means state bit i feeds the XOR. Must describe a maximal-length polynomial. The default is x^3+x+1.
- SEED, 1 (WIDTH bits): seed loaded at reset; must be nonzero.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled in IDLE or DONE only.
- hold  in  1  pauses the sweep while high.
- seed_load  in  1  loads seed_in into the seed register; honoured only when not busy.
- seed_in  in  WIDTH  new seed value.
- data_out  out  WIDTH  current pattern.
- valid  out  1  data_out is a pattern to be applied and counted this cycle.
- busy  out  1  a sweep is in progress.
- complete  out  1  sticky flag: the sweep finished.
- pattern_count  out  WIDTH+1  number of patterns consumed in the current sweep.

## Operation
- PERIOD = 2^WIDTH−1, or 2^WIDTH with TPG_ZERO_STATE_EN.
- FSM states:
  - IDLE: after reset.
  - RUN: entered on start from IDLE or DONE.
  - DONE: entered when the PERIOD-th pattern is consumed.
  - Any state → IDLE on reset.
- Feedback: fb = XOR over i of (data_out[i] & TAPS[i]). Next state = {data_out[WIDTH−2:0], fb}, a left shift with fb entering the LSB.
- Default sequence from 001: 001, 010, 101, 011, 111, 110, 100, then back to 001.
- Seed register:
  - Set to SEED on reset.
  - Set to seed_in on seed_load when not in RUN.
  - With the macro off, seed_in = 0 loads 1 instead, which prevents lock-up.
- On start, data_out ← seed register, pattern_count ← 0, complete ← 0.
  - If seed_load and start arrive in the same cycle, the sweep uses seed_in (after the zero substitution rule).
- valid = (state == RUN) & ~hold. This is combinational from registered state and hold.
- In RUN with valid = 1: data_out advances, pattern_count increments.
  - When pattern_count == PERIOD−1 on a consume, the next state is DONE.
- In RUN with hold = 1: data_out and pattern_count are frozen.
- DONE:
  - complete = 1, busy = 0, valid = 0.
  - data_out has advanced back to the seed, which acts as a self-check of maximality.
  - pattern_count = PERIOD.
  - complete stays set until the next start or reset.
- Ignored inputs:
  - start while in RUN.
  - seed_load while in RUN.
- busy = (state == RUN).

## Timing
- Reset values (one edge with reset = 1): state IDLE, data_out = SEED, valid = 0, busy = 0, complete = 0, pattern_count = 0, seed register = SEED.
- Start sampled at edge n:
  - From edge n, busy = 1 and data_out = seed.
  - The first valid pattern is visible in cycle n+1.
- With no hold: patterns occupy PERIOD consecutive cycles. complete rises at the edge after the last consume, which is PERIOD cycles after busy rose.
- Each hold cycle adds exactly one cycle of latency. Hold during IDLE or DONE has no effect.
- Reset mid-sweep: aborts at that edge to the reset values. The seed register returns to SEED, so any loaded seed is discarded.
- Restart from DONE: start clears complete at the same edge that sets busy.

## Configuration
- TPG_ZERO_STATE_EN defined:
  - Feedback becomes fb ^ (data_out[WIDTH−2:0] == 0). This is the de Bruijn extension, which inserts the all-zero state after 10…0.
  - PERIOD = 2^WIDTH.
  - A zero seed is legal and loads as 0.
  - Default sequence: 001, 010, 101, 011, 111, 110, 100, 000.
- Undefined:
  - Pure maximal LFSR; all-zero never appears.
  - PERIOD = 2^WIDTH−1.
  - A zero seed is replaced by 1.

## Test plan
- Defaults, macro off: reset, start.
  - Required: data_out 001, 010, 101, 011, 111, 110, 100 on 7 consecutive valid cycles.
  - Then complete = 1, busy = 0, data_out = 001, pattern_count = 7.
- Defaults, macro on: same stimulus.
  - Required: 8 patterns ending in 000; complete after 8; pattern_count = 8.
- Hold: assert hold for 3 cycles after the 2nd pattern.
  - Required: data_out frozen at 101, valid = 0 for those cycles.
  - complete is delayed by exactly 3 cycles; pattern_count still ends at 7.
- Seed handling:
  - seed_load with seed_in = 011 in IDLE, then start → first pattern 011, last 101.
  - seed_in = 000 with macro off → sweep starts at 001.
  - seed_load during RUN → ignored.
- Reset during RUN at the 4th pattern → next cycle shows IDLE reset values. A fresh start restarts from SEED = 001.
- WIDTH = 8, TAPS = 8'hB8:
  - 255 valid cycles, all patterns distinct and nonzero.
  - data_out returns to the seed; complete = 1.
  - start issued in DONE re-runs the sweep with complete cleared.
